// File: rtl/tb_dina_lane_mapper_if.sv
// Bundles the map, sequencer and output signals of the TB port-A dina mapper.
// The slave modport is the mapper's view; the master modport is the driver's view.
interface tb_dina_lane_mapper_if #(
  parameter int L          = 4,
  parameter int RSA_DW     = 32,
  parameter int NL_ROWS    = 2,
  parameter int SEQ_CNT_DW = 10,
  parameter int OFS_DW     = $clog2(L)
);
  logic                        in_valid;
  logic                        in_ready;
  logic [1:0]                  mode;
  logic [OFS_DW-1:0]           new_ofs;
  logic [L*RSA_DW-1:0]         din;
  logic                        nl_start;
  logic [NL_ROWS*L*RSA_DW-1:0] nl_coef;
  logic                        nl_busy;
  logic                        nl_done;
  logic [SEQ_CNT_DW-1:0]       nl_step;
  logic [L*RSA_DW-1:0]         dout;
  logic                        dout_valid;
  logic                        map_err;

  modport slave (
    input  in_valid, mode, new_ofs, din, nl_start, nl_coef,
    output in_ready, nl_busy, nl_done, nl_step, dout, dout_valid, map_err
  );
  modport master (
    output in_valid, mode, new_ofs, din, nl_start, nl_coef,
    input  in_ready, nl_busy, nl_done, nl_step, dout, dout_valid, map_err
  );
endinterface

// File: rtl/tb_dina_lane_mapper.sv
// TB port-A write-data mapper: lane-maps CB rows (pass/reverse/new-landmark) and
// replays a snapshotted coefficient matrix as a diagonally skewed systolic feed.
module tb_dina_lane #(
  parameter int J          = 0,
  parameter int RSA_DW     = 32,
  parameter int NL_ROWS    = 2,
  parameter int SEQ_CNT_DW = 10,
  parameter int OFS_DW     = 2
) (
  input  logic [1:0]                      mode,
  input  logic [OFS_DW-1:0]               new_ofs,
  input  logic [RSA_DW-1:0]               w_pos,
  input  logic [RSA_DW-1:0]               w_neg,
  input  logic [RSA_DW-1:0]               w0,
  input  logic [RSA_DW-1:0]               w1,
  input  logic [SEQ_CNT_DW-1:0]           cnt,
  input  logic [NL_ROWS-1:0][RSA_DW-1:0]  col,
  output logic [RSA_DW-1:0]               map_word,
  output logic [RSA_DW-1:0]               skew_word
);
  always_comb begin
    map_word = '0;
    case (mode)
      2'b01: map_word = w_pos;
      2'b10: map_word = w_neg;
      2'b11: begin
        if (int'(new_ofs) == J)          map_word = w0;
        else if (int'(new_ofs) + 1 == J) map_word = w1;
      end
      default: ;
    endcase
  end

  // Lane J sees row r at step r+J, giving the diagonal wavefront.
  always_comb begin
    skew_word = '0;
    for (int r = 0; r < NL_ROWS; r++)
      if (int'(cnt) == r + J) skew_word = col[r];
  end
endmodule

module tb_dina_lane_mapper #(
  parameter int L          = 4,
  parameter int X          = 4,
  parameter int RSA_DW     = 32,
  parameter int NL_ROWS    = 2,
  parameter int SEQ_CNT_DW = 10,
  parameter int OFS_DW     = $clog2(L)
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  tb_dina_lane_mapper_if.slave  bus
);
  localparam int S = NL_ROWS + L - 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  state_t state;

  logic [SEQ_CNT_DW-1:0]                 cnt;
  logic [NL_ROWS-1:0][L-1:0][RSA_DW-1:0] snap;
  logic [L-1:0][RSA_DW-1:0]              din_w, map_w, skew_w;
  logic                                  xfer, bad_ofs;

  assign din_w = bus.din;
  // The state term closes the one-cycle gap between start and the first busy cycle.
  assign bus.in_ready = !bus.nl_busy && !bus.nl_start && (state == ST_IDLE);
  assign xfer    = bus.in_valid && bus.in_ready;
  assign bad_ofs = (bus.mode == 2'b11) && (int'(bus.new_ofs) > L - 2);

  for (genvar j = 0; j < L; j++) begin : g_lane
    logic [NL_ROWS-1:0][RSA_DW-1:0] col;
    logic [RSA_DW-1:0]              w_neg;
    for (genvar r = 0; r < NL_ROWS; r++) begin : g_col
      assign col[r] = snap[r][j];
    end
    if (j < X) begin : g_neg
      assign w_neg = din_w[X-1-j];
    end else begin : g_nneg
      assign w_neg = '0;
    end
    tb_dina_lane #(
      .J(j), .RSA_DW(RSA_DW), .NL_ROWS(NL_ROWS),
      .SEQ_CNT_DW(SEQ_CNT_DW), .OFS_DW(OFS_DW)
    ) u_lane (
      .mode(bus.mode), .new_ofs(bus.new_ofs),
      .w_pos(din_w[j]), .w_neg(w_neg), .w0(din_w[0]), .w1(din_w[1]),
      .cnt(cnt), .col(col),
      .map_word(map_w[j]), .skew_word(skew_w[j])
    );
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      snap           <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.map_err    <= 1'b0;
      bus.nl_busy    <= 1'b0;
      bus.nl_done    <= 1'b0;
      bus.nl_step    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.nl_busy <= 1'b0;
          bus.nl_done <= 1'b0;
          if (bus.nl_start) begin
            snap  <= bus.nl_coef;
            cnt   <= '0;
            state <= ST_RUN;
          end
          if (xfer) begin
            bus.dout       <= bad_ofs ? '0 : map_w;
            bus.dout_valid <= 1'b1;
            bus.map_err    <= bad_ofs;
          end else begin
            bus.dout_valid <= 1'b0;
            bus.map_err    <= 1'b0;
          end
        end
        ST_RUN: begin
          bus.dout       <= skew_w;
          bus.dout_valid <= 1'b1;
          bus.map_err    <= 1'b0;
          bus.nl_busy    <= 1'b1;
          bus.nl_step    <= cnt;
          bus.nl_done    <= (cnt == SEQ_CNT_DW'(S - 1));
          if (cnt == SEQ_CNT_DW'(S - 1)) state <= ST_IDLE;
          else                           cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tb_dina_lane_mapper.sv
// Self-checking bench: vector table, randomized map traffic against a reference
// model, and hand sequences for the skew sequencer, collisions and mid-run reset.
module tb_tb_dina_lane_mapper;
  localparam int L  = 4;
  localparam int DW = 32;
  localparam int NL = 2;
  localparam int CW = 10;
  localparam int S  = NL + L - 1;
  localparam int BW = L * DW;

  logic clk = 1'b0;
  logic sys_rst_n;
  always #5 clk = ~clk;

  tb_dina_lane_mapper_if #(.L(L), .RSA_DW(DW), .NL_ROWS(NL), .SEQ_CNT_DW(CW)) bus ();
  tb_dina_lane_mapper_if #(.L(L), .RSA_DW(DW), .NL_ROWS(NL), .SEQ_CNT_DW(CW)) bus2 ();

  // Second instance with X=2 sees identical stimulus.
  assign bus2.in_valid = bus.in_valid;
  assign bus2.mode     = bus.mode;
  assign bus2.new_ofs  = bus.new_ofs;
  assign bus2.din      = bus.din;
  assign bus2.nl_start = bus.nl_start;
  assign bus2.nl_coef  = bus.nl_coef;

  tb_dina_lane_mapper #(.L(L), .X(4), .RSA_DW(DW), .NL_ROWS(NL), .SEQ_CNT_DW(CW)) u_dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus));
  tb_dina_lane_mapper #(.L(L), .X(2), .RSA_DW(DW), .NL_ROWS(NL), .SEQ_CNT_DW(CW)) u_dut_x2 (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus2));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]    mode;
    logic [1:0]    ofs;
    logic [BW-1:0] din;
    logic [BW-1:0] exp;
    logic [BW-1:0] exp2;
    logic          err;
  } vec_t;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [BW-1:0] ref_map(input int x, input logic [1:0] m, input int ofs,
                                            input logic [BW-1:0] d, output logic err);
    logic [DW-1:0] w [L];
    logic [DW-1:0] o [L];
    logic [BW-1:0] r;
    err = 1'b0;
    for (int i = 0; i < L; i++) begin w[i] = d[i*DW +: DW]; o[i] = '0; end
    case (m)
      2'd1: for (int i = 0; i < L; i++) o[i] = w[i];
      2'd2: for (int i = 0; i < x; i++) o[i] = w[x-1-i];
      2'd3: if (ofs <= L - 2) begin o[ofs] = w[0]; o[ofs+1] = w[1]; end else err = 1'b1;
      default: ;
    endcase
    r = '0;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = o[i];
    return r;
  endfunction

  function automatic logic [BW-1:0] ref_skew(input int s, input logic [NL*BW-1:0] coef);
    logic [BW-1:0] o;
    o = '0;
    for (int j = 0; j < L; j++)
      if (s - j >= 0 && s - j < NL) o[j*DW +: DW] = coef[((s-j)*L + j)*DW +: DW];
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [8];
    logic [BW-1:0] dA, hold, hold2, d, e, e2;
    logic [NL*BW-1:0] coef;
    logic v, er, er2, done_seen;
    logic [1:0] m;
    int o;

    dA = pack4(32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004);
    vt[0] = '{2'd1, 2'd0, pack4(1,2,3,4), pack4(1,2,3,4), pack4(1,2,3,4), 1'b0};
    vt[1] = '{2'd2, 2'd0, pack4(1,2,3,4), pack4(4,3,2,1), pack4(2,1,0,0), 1'b0};
    vt[2] = '{2'd3, 2'd0, dA, pack4(32'hAAAA0001,32'hBBBB0002,0,0), pack4(32'hAAAA0001,32'hBBBB0002,0,0), 1'b0};
    vt[3] = '{2'd3, 2'd2, dA, pack4(0,0,32'hAAAA0001,32'hBBBB0002), pack4(0,0,32'hAAAA0001,32'hBBBB0002), 1'b0};
    vt[4] = '{2'd3, 2'd3, dA, '0, '0, 1'b1};
    vt[5] = '{2'd3, 2'd1, dA, pack4(0,32'hAAAA0001,32'hBBBB0002,0), pack4(0,32'hAAAA0001,32'hBBBB0002,0), 1'b0};
    vt[6] = '{2'd0, 2'd0, dA, '0, '0, 1'b0};
    vt[7] = '{2'd1, 2'd3, dA, dA, dA, 1'b0};

    sys_rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.mode = 2'd0; bus.new_ofs = '0; bus.din = '0;
    bus.nl_start = 1'b0; bus.nl_coef = '0;
    tick(); tick();
    chk("rst_dout", bus.dout, '0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_nl_busy", bus.nl_busy, 0);
    chk("rst_nl_done", bus.nl_done, 0);
    chk("rst_nl_step", bus.nl_step, 0);
    chk("rst_map_err", bus.map_err, 0);
    sys_rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);

    // POS then hold
    bus.in_valid = 1'b1; bus.mode = 2'd1; bus.din = pack4(1,2,3,4);
    tick();
    chk("pos_dout", bus.dout, pack4(1,2,3,4));
    chk("pos_valid", bus.dout_valid, 1);
    bus.in_valid = 1'b0;
    tick();
    chk("hold_valid", bus.dout_valid, 0);
    chk("hold_dout", bus.dout, pack4(1,2,3,4));

    // Vector table, back-to-back
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.mode = vt[i].mode; bus.new_ofs = vt[i].ofs; bus.din = vt[i].din;
      tick();
      chk($sformatf("vec%0d_dout", i), bus.dout, vt[i].exp);
      chk($sformatf("vec%0d_dout_x2", i), bus2.dout, vt[i].exp2);
      chk($sformatf("vec%0d_valid", i), bus.dout_valid, 1);
      chk($sformatf("vec%0d_err", i), bus.map_err, vt[i].err);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("vec_end_valid", bus.dout_valid, 0);
    chk("vec_end_err", bus.map_err, 0);
    chk("vec_end_hold", bus.dout, vt[7].exp);
    hold = vt[7].exp; hold2 = vt[7].exp2;

    // Randomized map traffic
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      o = $urandom_range(0, 3);
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.in_valid = v; bus.mode = m; bus.new_ofs = 2'(o); bus.din = d;
      tick();
      er = 1'b0; er2 = 1'b0;
      if (v) begin
        e = ref_map(4, m, o, d, er); e2 = ref_map(2, m, o, d, er2);
        hold = e; hold2 = e2;
      end
      chk($sformatf("rnd%0d_dout", i), bus.dout, hold);
      chk($sformatf("rnd%0d_dout_x2", i), bus2.dout, hold2);
      chk($sformatf("rnd%0d_valid", i), bus.dout_valid, v);
      chk($sformatf("rnd%0d_err", i), bus.map_err, v && er);
    end
    bus.in_valid = 1'b0;
    tick();

    // Skew sequence with start/input collision, mid-run restart and coef change
    coef = '0;
    for (int r = 0; r < NL; r++)
      for (int j = 0; j < L; j++) coef[(r*L + j)*DW +: DW] = 32'hA0 + 32'(16*r + j);
    bus.nl_coef = coef; bus.nl_start = 1'b1;
    bus.in_valid = 1'b1; bus.mode = 2'd1; bus.din = pack4(9,9,9,9);
    tick();
    chk("start_not_accepted", bus.dout_valid, 0);
    chk("start_busy_low", bus.nl_busy, 0);
    bus.nl_start = 1'b0; bus.nl_coef = ~coef;
    for (int s = 0; s < S; s++) begin
      bus.nl_start = (s == 3);
      tick();
      chk($sformatf("skew%0d_dout", s), bus.dout, ref_skew(s, coef));
      chk($sformatf("skew%0d_valid", s), bus.dout_valid, 1);
      chk($sformatf("skew%0d_busy", s), bus.nl_busy, 1);
      chk($sformatf("skew%0d_step", s), bus.nl_step, s);
      chk($sformatf("skew%0d_done", s), bus.nl_done, s == S - 1);
      chk($sformatf("skew%0d_in_ready", s), bus.in_ready, 0);
      if (s == 1) chk("skew1_const", bus.dout, pack4(32'hB0, 32'hA1, 0, 0));
      if (s == S - 1) chk("skew_last_const", bus.dout, pack4(0, 0, 0, 32'hB3));
    end
    bus.nl_start = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("post_busy", bus.nl_busy, 0);
    chk("post_done", bus.nl_done, 0);
    chk("post_valid", bus.dout_valid, 0);
    chk("post_hold", bus.dout, pack4(0, 0, 0, 32'hB3));
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_step_hold", bus.nl_step, S - 1);

    // Reset while step 2 is on dout
    bus.nl_coef = coef; bus.nl_start = 1'b1;
    tick();
    bus.nl_start = 1'b0;
    tick(); tick(); tick();
    chk("mid_step2", bus.nl_step, 2);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", bus.dout, '0);
    chk("mid_rst_busy", bus.nl_busy, 0);
    chk("mid_rst_valid", bus.dout_valid, 0);
    chk("mid_rst_step", bus.nl_step, 0);
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();
    chk("after_rst_in_ready", bus.in_ready, 1);
    done_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.nl_done || bus.nl_busy) done_seen = 1'b1;
    end
    chk("after_rst_no_done", done_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
